// File: rtl/l2_request_arbiter_if.sv
// Bundle of the L1 instruction-side, L1 data-side and L2 CPU-side miss
// interfaces that meet at the L2 request arbiter.
interface l2_request_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // I-side (read only)
  logic                  i_read;
  logic [ADDR_W-1:0]     i_address;
  logic                  i_resp;
  logic [LINE_W-1:0]     i_rdata;
  // D-side (read / line write-back)
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_W-1:0]     d_address;
  logic [LINE_W-1:0]     d_wdata;
  logic [LINE_W/8-1:0]   d_byte_enable;
  logic                  d_resp;
  logic [LINE_W-1:0]     d_rdata;
  // L2 CPU-side port
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_W-1:0]     l2_address;
  logic [LINE_W-1:0]     l2_wdata;
  logic [LINE_W/8-1:0]   l2_byte_enable;
  logic                  l2_resp;
  logic [LINE_W-1:0]     l2_rdata;

  // Arbiter view: takes L1 requests and L2 responses, drives the rest.
  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  l2_resp, l2_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
    output l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable
  );

  // Environment view: L1 caches and L2 model.
  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata, d_byte_enable,
    output l2_resp, l2_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable
  );
endinterface

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the single L2 CPU-side port between the L1
// instruction cache and the L1 data cache. One grant at a time, held until
// the L2 responds, followed by one idle turnaround cycle.
module l2_request_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_request_arbiter_if.slave   bus
);

  localparam int BE_W  = LINE_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pri_q, pri_d;   // 0: I-side preferred, 1: D-side preferred
  logic   d_req;

  // Clear the byte-offset bits so the L2 always sees a line address.
  function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
    align_line = addr & ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  endfunction

  assign d_req = bus.d_read | bus.d_write;

  // Read data is shared; only the resp strobe says who it belongs to.
  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;

  // State and priority registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
    end
  end

  // Grant selection, L2 request steering and response routing.
  always_comb begin
    state_d            = state_q;
    pri_d              = pri_q;
    bus.l2_read        = 1'b0;
    bus.l2_write       = 1'b0;
    bus.l2_address     = '0;
    bus.l2_wdata       = '0;
    bus.l2_byte_enable = '0;
    bus.i_resp         = 1'b0;
    bus.d_resp         = 1'b0;

    case (state_q)
      IDLE: begin
        // A stray l2_resp here is deliberately ignored.
        if (bus.i_read && (!d_req || !pri_q)) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end

      SERVE_I: begin
        // Strobe follows the request so a withdrawn request stops driving L2.
        bus.l2_read        = bus.i_read;
        bus.l2_address     = align_line(bus.i_address);
        bus.l2_byte_enable = '1;
        bus.i_resp         = bus.l2_resp;
        if (bus.l2_resp) begin
          state_d = IDLE;
          pri_d   = 1'b1;
        end
      end

      SERVE_D: begin
        bus.l2_address = align_line(bus.d_address);
        if (bus.d_write) begin
          // Write-back wins over a simultaneous read.
          bus.l2_write       = 1'b1;
          bus.l2_wdata       = bus.d_wdata;
          bus.l2_byte_enable = bus.d_byte_enable;
        end else begin
          bus.l2_read        = bus.d_read;
          bus.l2_byte_enable = '1;
        end
        bus.d_resp = bus.l2_resp;
        if (bus.l2_resp) begin
          state_d = IDLE;
          pri_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: single-side transactions,
// round-robin alternation, read/write precedence, asynchronous reset and
// stray responses.
module tb_l2_request_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int BE_W   = LINE_W / 8;

  logic clk;
  logic rst;
  int   checks;
  int   errs;

  logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_d;
  logic [BE_W-1:0]   be_all, be_mix;

  l2_request_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  l2_request_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read        = 1'b0;
    bus.i_address     = '0;
    bus.d_read        = 1'b0;
    bus.d_write       = 1'b0;
    bus.d_address     = '0;
    bus.d_wdata       = '0;
    bus.d_byte_enable = '0;
    bus.l2_resp       = 1'b0;
    bus.l2_rdata      = '0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    pat_a  = {8{32'hA5A5_0001}};
    pat_b  = {8{32'hB00C_0002}};
    pat_c  = {8{32'hC3C3_0003}};
    pat_d  = {8{32'hD00D_0004}};
    be_all = '1;
    be_mix = {16{2'b10}};
    rst    = 1'b0;
    clear_inputs();

    // ---- reset state, with requests and a response already present
    bus.i_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.l2_resp = 1'b1;
    #12;
    chk("rst_l2_read",  bus.l2_read, 0);
    chk("rst_l2_write", bus.l2_write, 0);
    chk("rst_i_resp",   bus.i_resp, 0);
    chk("rst_d_resp",   bus.d_resp, 0);
    chk("rst_l2_addr",  bus.l2_address, 0);
    chk("rst_l2_wdata", bus.l2_wdata, 0);
    chk("rst_l2_be",    bus.l2_byte_enable, 0);
    clear_inputs();
    #2 rst = 1'b1;
    step();

    // ---- I-only read; cycle T is the first cycle the request is high
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_1234;
    #1 chk("i_T_l2_read", bus.l2_read, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = pat_a;
      end
      #1;
      chk($sformatf("i_T%0d_l2_read", c), bus.l2_read, 1);
      chk($sformatf("i_T%0d_l2_write", c), bus.l2_write, 0);
      chk($sformatf("i_T%0d_addr", c), bus.l2_address, 32'h0000_1220);
      chk($sformatf("i_T%0d_be", c), bus.l2_byte_enable, be_all);
      chk($sformatf("i_T%0d_i_resp", c), bus.i_resp, (c == 3));
      chk($sformatf("i_T%0d_d_resp", c), bus.d_resp, 0);
    end
    chk("i_rdata", bus.i_rdata, pat_a);
    chk("d_rdata_mirror", bus.d_rdata, pat_a);
    step();
    bus.i_read  = 1'b0;
    bus.l2_resp = 1'b0;
    #1;
    chk("i_T4_l2_read", bus.l2_read, 0);
    chk("i_T4_i_resp",  bus.i_resp, 0);
    step();

    // ---- D write-back, response two cycles after the grant
    bus.d_write       = 1'b1;
    bus.d_address     = 32'h8000_0040;
    bus.d_wdata       = pat_b;
    bus.d_byte_enable = be_all;
    step();
    #1;
    chk("dw_l2_write", bus.l2_write, 1);
    chk("dw_l2_read",  bus.l2_read, 0);
    chk("dw_wdata",    bus.l2_wdata, pat_b);
    chk("dw_addr",     bus.l2_address, 32'h8000_0040);
    chk("dw_be",       bus.l2_byte_enable, be_all);
    chk("dw_d_resp_early", bus.d_resp, 0);
    step();
    bus.l2_resp = 1'b1;
    #1;
    chk("dw_d_resp", bus.d_resp, 1);
    chk("dw_i_resp", bus.i_resp, 0);
    step();
    clear_inputs();
    #1;
    chk("dw_after_d_resp",   bus.d_resp, 0);
    chk("dw_after_l2_write", bus.l2_write, 0);
    step();

    // ---- both sides request after reset: I, idle, D, idle, I
    pulse_reset();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h2000_0000;
    step();
    bus.l2_resp = 1'b1;
    #1;
    chk("rr1_l2_read", bus.l2_read, 1);
    chk("rr1_addr",    bus.l2_address, 32'h0000_0100);
    chk("rr1_i_resp",  bus.i_resp, 1);
    chk("rr1_d_resp",  bus.d_resp, 0);
    step();
    bus.l2_resp = 1'b0;
    #1;
    chk("rr1_turn_l2_read", bus.l2_read, 0);
    step();
    bus.l2_resp = 1'b1;
    #1;
    chk("rr2_l2_read", bus.l2_read, 1);
    chk("rr2_addr",    bus.l2_address, 32'h2000_0000);
    chk("rr2_d_resp",  bus.d_resp, 1);
    chk("rr2_i_resp",  bus.i_resp, 0);
    step();
    bus.l2_resp = 1'b0;
    #1;
    chk("rr2_turn_l2_read", bus.l2_read, 0);
    step();
    bus.l2_resp = 1'b1;
    #1;
    chk("rr3_addr",   bus.l2_address, 32'h0000_0100);
    chk("rr3_i_resp", bus.i_resp, 1);
    chk("rr3_d_resp", bus.d_resp, 0);
    step();
    clear_inputs();
    step();

    // ---- D read and write together: write wins
    bus.d_read        = 1'b1;
    bus.d_write       = 1'b1;
    bus.d_address     = 32'h0000_ABFF;
    bus.d_wdata       = pat_c;
    bus.d_byte_enable = be_mix;
    step();
    #1;
    chk("drw_l2_write", bus.l2_write, 1);
    chk("drw_l2_read",  bus.l2_read, 0);
    chk("drw_addr",     bus.l2_address, 32'h0000_ABE0);
    chk("drw_be",       bus.l2_byte_enable, be_mix);
    chk("drw_wdata",    bus.l2_wdata, pat_c);
    bus.l2_resp = 1'b1;
    step();
    clear_inputs();
    step();

    // ---- asynchronous reset while serving D (pri left at 1 beforehand)
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0300;
    step();
    bus.l2_resp = 1'b1;
    step();
    clear_inputs();
    bus.d_read    = 1'b1;
    bus.d_address = 32'h4000_0080;
    step();
    step();
    chk("ar_pre_l2_read", bus.l2_read, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_l2_read",  bus.l2_read, 0);
    chk("ar_l2_write", bus.l2_write, 0);
    chk("ar_l2_addr",  bus.l2_address, 0);
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0500;
    #2 rst = 1'b1;
    step();
    #1;
    chk("ar_regrant_l2_read", bus.l2_read, 1);
    chk("ar_regrant_addr",    bus.l2_address, 32'h0000_0500);
    bus.l2_resp = 1'b1;
    step();
    clear_inputs();
    step();

    // ---- stray response while idle
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = pat_d;
    #1;
    chk("stray_i_resp", bus.i_resp, 0);
    chk("stray_d_resp", bus.d_resp, 0);
    chk("stray_rdata_mirror", bus.i_rdata, pat_d);
    step();
    bus.l2_resp = 1'b0;
    #1;
    chk("stray_idle_l2_read", bus.l2_read, 0);
    chk("stray_idle_i_resp",  bus.i_resp, 0);
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_0777;
    step();
    #1;
    chk("stray_next_l2_read", bus.l2_read, 1);
    chk("stray_next_addr",    bus.l2_address, 32'h0000_0760);
    bus.l2_resp = 1'b1;
    step();
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
